// File: rtl/shuffle_mem_fsm.sv
// RC4 key-scheduling shuffle engine.
// Walks i = 0..255 over a 256x8 S-memory that already holds s[i] = i.
// For each i: j += s[i] + key[i mod KEY_LENGTH], then s[i] and s[j] are swapped.
// The memory is synchronous: mem_q shows s[mem_address] one cycle after the address is presented.
// Each iteration therefore takes six cycles: read i, wait, read j, wait, write i, write j.
module shuffle_mem_fsm #(
   parameter int KEY_LENGTH = 3
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      start_shuffle,
   input  logic [8*KEY_LENGTH-1:0]   secret_key,
   input  logic [7:0]                mem_q,
   output logic [7:0]                mem_address,
   output logic [7:0]                mem_data,
   output logic                      mem_wren,
   output logic                      busy,
   output logic                      shuffle_mem_finished
);

   localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(KEY_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      LAT_I,
      RD_J,
      LAT_J,
      WR_I,
      WR_J,
      DONE
   } state_t;

   state_t                    state;
   logic [7:0]                i;
   logic [7:0]                j;
   logic [7:0]                si;
   logic [KW-1:0]             k;
   logic [8*KEY_LENGTH-1:0]   key_reg;
   logic [7:0]                j_next;

   // Key byte 0 sits in the most significant byte of the key word.
   function automatic logic [7:0] key_byte(input logic [8*KEY_LENGTH-1:0] key,
                                           input logic [KW-1:0] idx);
      return key[(8*KEY_LENGTH-1) - 8*int'(idx) -: 8];
   endfunction

   // Next j: s[i] arrives on mem_q in LAT_I; the sum wraps modulo 256.
   always_comb begin
      j_next = j + mem_q + key_byte(key_reg, k);
   end

   // Shuffle sequencer; memory controls are registered so they are valid for the whole named state.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state                <= IDLE;
         i                    <= 8'd0;
         j                    <= 8'd0;
         k                    <= '0;
         si                   <= 8'd0;
         mem_address          <= 8'd0;
         mem_data             <= 8'd0;
         mem_wren             <= 1'b0;
         busy                 <= 1'b0;
         shuffle_mem_finished <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_shuffle) begin
                  state                <= RD_I;
                  key_reg              <= secret_key;
                  i                    <= 8'd0;
                  j                    <= 8'd0;
                  k                    <= '0;
                  mem_address          <= 8'd0;
                  mem_wren             <= 1'b0;
                  busy                 <= 1'b1;
                  shuffle_mem_finished <= 1'b0;
               end
            end
            RD_I: begin
               state <= LAT_I;
            end
            LAT_I: begin
               si          <= mem_q;
               j           <= j_next;
               mem_address <= j_next;
               state       <= RD_J;
            end
            RD_J: begin
               state <= LAT_J;
            end
            LAT_J: begin
               // s[j] goes straight into the write-data register for the s[i] write.
               mem_address <= i;
               mem_data    <= mem_q;
               mem_wren    <= 1'b1;
               state       <= WR_I;
            end
            WR_I: begin
               mem_address <= j;
               mem_data    <= si;
               state       <= WR_J;
            end
            WR_J: begin
               mem_wren <= 1'b0;
               if (i == 8'd255) begin
                  busy                 <= 1'b0;
                  shuffle_mem_finished <= 1'b1;
                  state                <= DONE;
               end else begin
                  i           <= i + 8'd1;
                  k           <= (k == K_LAST) ? '0 : k + 1'b1;
                  mem_address <= i + 8'd1;
                  state       <= RD_I;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shuffle_mem_fsm.sv
// Directed bench for shuffle_mem_fsm with a synchronous 256x8 memory model and a write scoreboard.
module tb_shuffle_mem_fsm;

   logic        clk;
   logic        reset;
   logic        start_shuffle;
   logic [23:0] secret_key;
   logic [7:0]  mem_q;
   logic [7:0]  mem_address;
   logic [7:0]  mem_data;
   logic        mem_wren;
   logic        busy;
   logic        shuffle_mem_finished;

   logic [7:0]  mem [256];
   logic        init_mem;
   logic [7:0]  ref_s [256];
   logic [15:0] sb_q [$];
   logic [15:0] exp_w;

   int vectors;
   int errors;

   shuffle_mem_fsm #(.KEY_LENGTH(3)) dut (
      .CLOCK_50             (clk),
      .reset                (reset),
      .start_shuffle        (start_shuffle),
      .secret_key           (secret_key),
      .mem_q                (mem_q),
      .mem_address          (mem_address),
      .mem_data             (mem_data),
      .mem_wren             (mem_wren),
      .busy                 (busy),
      .shuffle_mem_finished (shuffle_mem_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous S-memory: registered read, write on the edge; init_mem reloads s[i] = i.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
      end else if (mem_wren) begin
         mem[mem_address] <= mem_data;
      end
      mem_q <= mem[mem_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Every write the DUT issues must be the next one predicted by the reference KSA.
   always @(negedge clk) begin
      if (!reset && mem_wren) begin
         check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            check("sb_write_addr_data", 32'({mem_address, mem_data}), 32'(exp_w));
         end
      end
   end

   // Reference RC4 key schedule: queues the expected write sequence and keeps the final S.
   task automatic load_ref(input logic [23:0] key);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] jj;
      logic [7:0] t;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      jj = 8'd0;
      sb_q.delete();
      for (int n = 0; n < 256; n++) begin
         jj = jj + s[n] + kb[n % 3];
         sb_q.push_back({8'(n), s[jj]});
         sb_q.push_back({jj, s[n]});
         t     = s[n];
         s[n]  = s[jj];
         s[jj] = t;
      end
      for (int n = 0; n < 256; n++) ref_s[n] = s[n];
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic init_memory();
      init_mem = 1'b1;
      step(1);
      init_mem = 1'b0;
   endtask

   // Pulses start for one cycle; returns at the middle of cycle 1 (first RD_I cycle).
   task automatic do_start(input logic [23:0] key);
      secret_key = key;
      load_ref(key);
      start_shuffle = 1'b1;
      step(1);
      start_shuffle = 1'b0;
   endtask

   task automatic wait_finish(input int cyc_now);
      int   c;
      logic prev_busy;
      c = cyc_now;
      prev_busy = busy;
      while (!shuffle_mem_finished && c < 2000) begin
         prev_busy = busy;
         step(1);
         c++;
      end
      check("finish_cycle", 32'(c), 32'd1537);
      check("busy_before_finish", 32'(prev_busy), 32'd1);
      check("busy_at_finish", 32'(busy), 32'd0);
      check("wren_at_finish", 32'(mem_wren), 32'd0);
   endtask

   task automatic check_final();
      logic [255:0] seen;
      seen = '0;
      for (int n = 0; n < 256; n++) begin
         check("final_s", 32'({8'(n), mem[n]}), 32'({8'(n), ref_s[n]}));
         seen[mem[n]] = 1'b1;
      end
      check("permutation", 32'(&seen), 32'd1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      vectors       = 0;
      errors        = 0;
      init_mem      = 1'b0;
      reset         = 1'b1;
      start_shuffle = 1'b1;
      secret_key    = 24'hFFFFFF;

      // Reset held three cycles with start high: everything stays cleared.
      for (int n = 0; n < 3; n++) begin
         step(1);
         check("rst_addr", 32'(mem_address), 32'd0);
         check("rst_data", 32'(mem_data), 32'd0);
         check("rst_wren", 32'(mem_wren), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_finished", 32'(shuffle_mem_finished), 32'd0);
      end
      reset         = 1'b0;
      start_shuffle = 1'b0;
      step(1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_wren", 32'(mem_wren), 32'd0);

      // Key 0x010203: first two iterations, then reset mid-run at cycle 700.
      init_memory();
      do_start(24'h010203);
      check("k123_busy_c1", 32'(busy), 32'd1);
      check("k123_addr_c1", 32'(mem_address), 32'd0);
      step(8);
      check("k123_j_iter1", 32'(mem_address), 32'd3);
      step(4);
      check("k123_s0", 32'(mem[0]), 32'd1);
      check("k123_s1", 32'(mem[1]), 32'd3);
      check("k123_s3", 32'(mem[3]), 32'd0);
      step(687);
      reset = 1'b1;
      step(1);
      check("abort_wren", 32'(mem_wren), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_finished", 32'(shuffle_mem_finished), 32'd0);
      check("abort_addr", 32'(mem_address), 32'd0);
      reset = 1'b0;
      sb_q.delete();
      step(2);
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_idle_wren", 32'(mem_wren), 32'd0);

      // Key 0x000249 full run, with an extra start at cycle 10 that must be ignored.
      init_memory();
      do_start(24'h000249);
      check("k249_busy_c1", 32'(busy), 32'd1);
      check("k249_wren_c1", 32'(mem_wren), 32'd0);
      step(9);
      start_shuffle = 1'b1;
      step(1);
      start_shuffle = 1'b0;
      wait_finish(11);
      check_final();

      // Finished is a level while DONE.
      step(3);
      check("done_hold_finished", 32'(shuffle_mem_finished), 32'd1);
      check("done_hold_busy", 32'(busy), 32'd0);

      // Key 0x000000 started from DONE: iteration 0 has i == j == 0.
      init_memory();
      do_start(24'h000000);
      check("k0_finished_drop", 32'(shuffle_mem_finished), 32'd0);
      check("k0_busy_c1", 32'(busy), 32'd1);
      step(4);
      check("k0_wri", 32'({mem_wren, mem_address, mem_data}), 32'h10000);
      step(1);
      check("k0_wrj", 32'({mem_wren, mem_address, mem_data}), 32'h10000);
      step(1);
      check("k0_s0", 32'(mem[0]), 32'd0);
      wait_finish(7);
      check_final();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
